// File: rtl/dds_sweep_ctrl.sv
// ============================================================================
//  Module   : dds_sweep_ctrl
//  Purpose  : Frequency sweep / hop sequencer driving DDS frequency, phase and
//             waveform control words (single, repeat and up-down sweeps).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_ctrl #(
    parameter int FW = 10,
    parameter int PW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [1:0]    cfg_shape,
    input  logic [PW-1:0] cfg_pword,
    input  logic          start,
    input  logic          stop,
    output logic [FW-1:0] fword,
    output logic [PW-1:0] pword,
    output logic [1:0]    wave_shape,
    output logic          busy,
    output logic          step_strobe,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_REPEAT = 2'b01;
    localparam logic [1:0] c_MODE_UPDOWN = 2'b10;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [FW-1:0] r_f_start;
    logic [FW-1:0] r_f_stop;
    logic [FW-1:0] r_f_step;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_mode;
    logic [1:0]    r_shape;
    logic [PW-1:0] r_pword;

    logic [FW-1:0] r_fword;
    logic [FW-1:0] w_fword_nxt;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_nxt;
    logic          r_strobe;
    logic          w_strobe_nxt;
    logic          r_done;
    logic          w_done_nxt;

    logic          w_cfg_fire;
    logic          w_start_ok;
    logic          w_dwell_end;
    logic [FW-1:0] w_step_eff;

    logic [FW:0]          w_up_sum;
    logic [FW-1:0]        w_up_val;
    logic signed [FW+1:0] w_dn_diff;
    logic [FW-1:0]        w_dn_val;
    logic [FW:0]          w_tu_sum;
    logic [FW-1:0]        w_turn_up;
    logic signed [FW+1:0] w_td_diff;
    logic [FW-1:0]        w_turn_dn;

    assign cfg_ready   = (r_state == S_IDLE);
    assign w_cfg_fire  = cfg_valid & cfg_ready;
    assign w_start_ok  = start & ~stop & (r_f_start <= r_f_stop);
    assign w_dwell_end = (r_cnt == '0);
    assign w_step_eff  = (r_f_step == '0) ? {{(FW-1){1'b0}}, 1'b1} : r_f_step;

    // One bit of headroom on the way up and a sign bit on the way down
    // make the clamps exact for any step size.
    assign w_up_sum  = {1'b0, r_fword} + {1'b0, w_step_eff};
    assign w_up_val  = (w_up_sum > {1'b0, r_f_stop}) ? r_f_stop : w_up_sum[FW-1:0];
    assign w_dn_diff = $signed({2'b00, r_fword}) - $signed({2'b00, w_step_eff});
    assign w_dn_val  = (w_dn_diff < $signed({2'b00, r_f_start})) ? r_f_start
                                                                  : w_dn_diff[FW-1:0];

    assign w_tu_sum  = {1'b0, r_f_start} + {1'b0, w_step_eff};
    assign w_turn_up = (w_tu_sum > {1'b0, r_f_stop}) ? r_f_stop : w_tu_sum[FW-1:0];
    assign w_td_diff = $signed({2'b00, r_f_stop}) - $signed({2'b00, w_step_eff});
    assign w_turn_dn = (w_td_diff < $signed({2'b00, r_f_start})) ? r_f_start
                                                                  : w_td_diff[FW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_fword_nxt  = r_fword;
        w_cnt_nxt    = r_cnt;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_UP;
                    w_fword_nxt = r_f_start;
                    w_cnt_nxt   = r_dwell;
                end
            end
            S_UP, S_DOWN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_dwell_end) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_cnt_nxt    = r_dwell;
                    w_strobe_nxt = 1'b1;
                    if (r_state == S_UP) begin
                        if (r_fword == r_f_stop) begin
                            if (r_mode == c_MODE_UPDOWN) begin
                                w_state_nxt = S_DOWN;
                                w_fword_nxt = w_turn_dn;
                            end else if (r_mode == c_MODE_REPEAT) begin
                                w_fword_nxt = r_f_start;
                            end else begin
                                w_state_nxt  = S_IDLE;
                                w_strobe_nxt = 1'b0;
                                w_done_nxt   = 1'b1;
                            end
                        end else begin
                            w_fword_nxt = w_up_val;
                        end
                    end else begin
                        if (r_fword == r_f_start) begin
                            w_state_nxt = S_UP;
                            w_fword_nxt = w_turn_up;
                        end else begin
                            w_fword_nxt = w_dn_val;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_fword  <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fword  <= w_fword_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Shadow config: only written from IDLE, so a running sweep never sees it change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_mode    <= '0;
            r_shape   <= '0;
            r_pword   <= '0;
        end else if (w_cfg_fire) begin
            r_f_start <= cfg_f_start;
            r_f_stop  <= cfg_f_stop;
            r_f_step  <= cfg_f_step;
            r_dwell   <= cfg_dwell;
            r_mode    <= cfg_mode;
            r_shape   <= cfg_shape;
            r_pword   <= cfg_pword;
        end
    end

    assign fword       = r_fword;
    assign pword       = r_pword;
    assign wave_shape  = r_shape;
    assign busy        = (r_state != S_IDLE);
    assign step_strobe = r_strobe;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ============================================================================
//  Module   : tb_dds_sweep_ctrl
//  Purpose  : Directed self-checking bench for dds_sweep_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_f_start;
    logic [9:0]  cfg_f_stop;
    logic [9:0]  cfg_f_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [1:0]  cfg_shape;
    logic [9:0]  cfg_pword;
    logic        start;
    logic        stop;
    logic [9:0]  fword;
    logic [9:0]  pword;
    logic [1:0]  wave_shape;
    logic        busy;
    logic        step_strobe;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    dds_sweep_ctrl #(.FW(10), .PW(10), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_shape(cfg_shape),
        .cfg_pword(cfg_pword), .start(start), .stop(stop),
        .fword(fword), .pword(pword), .wave_shape(wave_shape),
        .busy(busy), .step_strobe(step_strobe), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [9:0] fs, input logic [9:0] fe, input logic [9:0] st,
                           input logic [15:0] dw, input logic [1:0] md, input logic [1:0] sh,
                           input logic [9:0] pw);
        cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
        cfg_dwell = dw; cfg_mode = md; cfg_shape = sh; cfg_pword = pw;
    endtask

    task automatic load_cfg(input logic [9:0] fs, input logic [9:0] fe, input logic [9:0] st,
                            input logic [15:0] dw, input logic [1:0] md, input logic [1:0] sh,
                            input logic [9:0] pw);
        set_cfg(fs, fe, st, dw, md, sh, pw);
        cfg_valid = 1'b1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        n_checks++;
        if (pword !== pw || wave_shape !== sh) begin
            n_errors++;
            $display("FAIL cfg_outputs pword=%0d exp=%0d shape=%0d exp=%0d", pword, pw, wave_shape, sh);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (fword !== 10'd0 || pword !== 10'd0 || wave_shape !== 2'd0 || busy !== 1'b0 ||
            done !== 1'b0 || step_strobe !== 1'b0 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state fword=%0d pword=%0d shape=%0d busy=%b done=%b strobe=%b ready=%b exp=0,0,0,0,0,0,1",
                     fword, pword, wave_shape, busy, done, step_strobe, cfg_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [9:0] ef;
        logic       es;
        load_cfg(10'd100, 10'd130, 10'd10, 16'd2, 2'b00, 2'd1, 10'd33);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            ef = 10'(100 + 10 * ((k - 1) / 3));
            es = (k == 4 || k == 7 || k == 10);
            n_checks++;
            if (fword !== ef || step_strobe !== es || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL single cyc=%0d fword=%0d exp=%0d strobe=%b exp=%b busy=%b exp=1 done=%b exp=0",
                         k, fword, ef, step_strobe, es, busy, done);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fword !== 10'd130 || step_strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL single_done done=%b exp=1 busy=%b exp=0 fword=%0d exp=130 strobe=%b exp=0",
                     done, busy, fword, step_strobe);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || fword !== 10'd130) begin
            n_errors++;
            $display("FAIL single_after done=%b exp=0 fword=%0d exp=130", done, fword);
        end
    endtask

    task automatic test_saturate();
        logic [9:0] e1 [3] = '{10'd1000, 10'd1015, 10'd1020};
        logic [9:0] e2 [2] = '{10'd1000, 10'd1023};
        load_cfg(10'd1000, 10'd1020, 10'd15, 16'd0, 2'b00, 2'd0, 10'd0);
        do_start();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (fword !== e1[k] || step_strobe !== (k > 0) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL sat cyc=%0d fword=%0d exp=%0d strobe=%b busy=%b", k, fword, e1[k], step_strobe, busy);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fword !== 10'd1020) begin
            n_errors++;
            $display("FAIL sat_done done=%b busy=%b fword=%0d exp=1,0,1020", done, busy, fword);
        end
        load_cfg(10'd1000, 10'd1023, 10'd100, 16'd0, 2'b00, 2'd0, 10'd0);
        do_start();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (fword !== e2[k] || step_strobe !== (k > 0) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL ovf cyc=%0d fword=%0d exp=%0d strobe=%b busy=%b", k, fword, e2[k], step_strobe, busy);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fword !== 10'd1023) begin
            n_errors++;
            $display("FAIL ovf_done done=%b busy=%b fword=%0d exp=1,0,1023", done, busy, fword);
        end
    endtask

    task automatic test_updown();
        logic [9:0] ef [9] = '{10'd10, 10'd20, 10'd30, 10'd20, 10'd10, 10'd20, 10'd30, 10'd20, 10'd10};
        load_cfg(10'd10, 10'd30, 10'd10, 16'd0, 2'b10, 2'd2, 10'd5);
        do_start();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fword !== ef[k] || step_strobe !== (k > 0) || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL updown cyc=%0d fword=%0d exp=%0d strobe=%b busy=%b done=%b",
                         k, fword, ef[k], step_strobe, busy, done);
            end
            if (k < 8) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || fword !== 10'd10 || step_strobe !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL updown_stop busy=%b fword=%0d strobe=%b done=%b exp=0,10,0,0",
                     busy, fword, step_strobe, done);
        end
    endtask

    task automatic test_repeat_stop();
        logic [9:0] ef [9] = '{10'd100, 10'd100, 10'd110, 10'd110, 10'd120, 10'd120, 10'd100, 10'd100, 10'd110};
        logic       es;
        load_cfg(10'd100, 10'd120, 10'd10, 16'd1, 2'b01, 2'd3, 10'd200);
        do_start();
        for (int k = 1; k <= 9; k++) begin
            es = (k == 3 || k == 5 || k == 7 || k == 9);
            n_checks++;
            if (fword !== ef[k-1] || step_strobe !== es || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL repeat cyc=%0d fword=%0d exp=%0d strobe=%b exp=%b busy=%b done=%b",
                         k, fword, ef[k-1], step_strobe, es, busy, done);
            end
            if (k < 9) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy !== 1'b0 || fword !== 10'd110 || step_strobe !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL repeat_stop cyc=%0d busy=%b fword=%0d strobe=%b done=%b exp=0,110,0,0",
                         k, busy, fword, step_strobe, done);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        load_cfg(10'd300, 10'd400, 10'd1, 16'd0, 2'b01, 2'd3, 10'd9);
        do_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (fword !== 10'd0 || pword !== 10'd0 || wave_shape !== 2'd0 || busy !== 1'b0 ||
            done !== 1'b0 || step_strobe !== 1'b0 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid fword=%0d pword=%0d shape=%0d busy=%b done=%b strobe=%b ready=%b exp=0,0,0,0,0,0,1",
                     fword, pword, wave_shape, busy, done, step_strobe, cfg_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (fword !== 10'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_after fword=%0d busy=%b ready=%b exp=0,0,1", fword, busy, cfg_ready);
        end
    endtask

    task automatic test_reject();
        // Mode 11 behaves as single; equal start/stop finishes after one dwell.
        load_cfg(10'd7, 10'd7, 10'd3, 16'd0, 2'b11, 2'd1, 10'd11);
        do_start();
        n_checks++;
        if (fword !== 10'd7 || busy !== 1'b1 || step_strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL eq_start fword=%0d busy=%b strobe=%b exp=7,1,0", fword, busy, step_strobe);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fword !== 10'd7) begin
            n_errors++;
            $display("FAIL eq_done done=%b busy=%b fword=%0d exp=1,0,7", done, busy, fword);
        end
        load_cfg(10'd50, 10'd40, 10'd1, 16'd0, 2'b00, 2'd0, 10'd0);
        do_start();
        n_checks++;
        if (busy !== 1'b0 || fword !== 10'd7 || step_strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_range busy=%b fword=%0d strobe=%b exp=0,7,0", busy, fword, step_strobe);
        end
        load_cfg(10'd50, 10'd60, 10'd1, 16'd0, 2'b01, 2'd0, 10'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || fword !== 10'd7) begin
            n_errors++;
            $display("FAIL start_with_stop busy=%b fword=%0d exp=0,7", busy, fword);
        end
        set_cfg(10'd300, 10'd400, 10'd1, 16'd0, 2'b01, 2'd2, 10'd123);
        cfg_valid = 1'b1;
        start     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || fword !== 10'd50 || pword !== 10'd123 || wave_shape !== 2'd2) begin
            n_errors++;
            $display("FAIL start_and_cfg busy=%b fword=%0d pword=%0d shape=%0d exp=1,50,123,2",
                     busy, fword, pword, wave_shape);
        end
        set_cfg(10'd900, 10'd950, 10'd1, 16'd0, 2'b00, 2'd1, 10'd456);
        cfg_valid = 1'b1;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_busy got=%b exp=0", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        n_checks++;
        if (pword !== 10'd123 || wave_shape !== 2'd2) begin
            n_errors++;
            $display("FAIL shadow_busy pword=%0d shape=%0d exp=123,2", pword, wave_shape);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_start();
        n_checks++;
        if (busy !== 1'b1 || fword !== 10'd300) begin
            n_errors++;
            $display("FAIL shadow_kept busy=%b fword=%0d exp=1,300", busy, fword);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_step_zero();
        load_cfg(10'd5, 10'd8, 10'd0, 16'd0, 2'b00, 2'd0, 10'd0);
        do_start();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (fword !== 10'(5 + k) || step_strobe !== (k > 0) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL step0 cyc=%0d fword=%0d exp=%0d strobe=%b busy=%b",
                         k, fword, 5 + k, step_strobe, busy);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fword !== 10'd8) begin
            n_errors++;
            $display("FAIL step0_done done=%b busy=%b fword=%0d exp=1,0,8", done, busy, fword);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        set_cfg(10'd0, 10'd0, 10'd0, 16'd0, 2'd0, 2'd0, 10'd0);
        test_reset();
        test_single();
        test_saturate();
        test_updown();
        test_repeat_stop();
        test_reset_mid();
        test_reject();
        test_step_zero();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sweep and hop sequencer that drives the frequency, phase and waveform control words of the DDS signal generator.
A host loads a sweep configuration through a valid/ready handshake, then pulses start.
The block steps the frequency word from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
It supports single-shot, repeating and up-down (triangular) sweeps, and sits between the host register interface and the DDS control inputs.

Parameters:
FW, 10, frequency word width (matches DDS Fword)
PW, 10, phase word width (matches DDS Pword)
DW, 16, dwell counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_f_start  in  FW  first frequency word
cfg_f_stop  in  FW  last frequency word
cfg_f_step  in  FW  increment per step
cfg_dwell  in  DW  each value held cfg_dwell+1 cycles
cfg_mode  in  2  00 single, 01 repeat, 10 up-down, 11 treated as 00
cfg_shape  in  2  waveform select passed to DDS
cfg_pword  in  PW  phase offset passed to DDS
start  in  1  begin sweep (level sampled each cycle)
stop  in  1  abort sweep
fword  out  FW  DDS frequency word
pword  out  PW  DDS phase word
wave_shape  out  2  DDS waveform select
busy  out  1  sweep in progress
step_strobe  out  1  1-cycle pulse when fword changes during a sweep
done  out  1  1-cycle pulse on normal single-mode completion

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset: fword=0, pword=0, wave_shape=0, busy=0, done=0, step_strobe=0, cfg_ready=1, state IDLE. Shadow config registers clear to 0.
- cfg_ready = (state==IDLE). On cfg_valid&cfg_ready, all cfg_* fields are latched into shadow registers.
- pword and wave_shape update the cycle after the handshake. fword is unchanged by the handshake.
- States: IDLE, UP, DOWN.
- Start (IDLE only):
  - Start is accepted when start=1, stop=0 and shadow f_start<=f_stop.
  - On acceptance at edge t: fword=f_start and busy=1 from t+1. The dwell counter loads dwell. State goes to UP.
  - If f_start>f_stop, start is ignored: stay IDLE, no pulse.
  - If start and cfg_valid are both high in IDLE, the handshake completes and start uses the old shadow values.
- Dwell: in UP or DOWN, the counter decrements each cycle. The step action occurs on the cycle the counter equals 0, and the counter then reloads dwell. Each fword value is therefore visible exactly dwell+1 cycles.
- Step arithmetic: computed at FW+1 bits, so there is no wraparound. Step value 0 is treated as 1.
  - UP: if fword==f_stop, end-of-leg. Otherwise fword<=min(fword+step, f_stop).
  - DOWN: if fword==f_start, end-of-leg. Otherwise fword<=max(fword-step, f_start), computed as a signed compare.
- End-of-leg:
  - single (UP): go to IDLE, busy=0, done=1 for one cycle, fword holds f_stop.
  - repeat (UP): fword<=f_start.
  - up-down: UP→DOWN with fword<=max(f_stop-step, f_start); DOWN→UP with fword<=min(f_start+step, f_stop).
- f_start==f_stop:
  - single: finishes after one dwell.
  - repeat and up-down: run forever at a constant value, with step_strobe still pulsing each dwell.
- step_strobe: high for one cycle in the same cycle the new fword appears, for every step/wrap/turnaround inside a sweep. It is not asserted for the initial load at start, nor on completion.
- stop: in UP or DOWN, the next state is IDLE and busy=0. fword holds its current value. No done pulse and no step_strobe. stop has priority over a simultaneous step.
- start while busy is ignored. cfg_valid while busy is not accepted.
- rst mid-sweep returns all outputs to reset values on the next edge.

Test Plan:
1. Assert rst for 2 cycles mid-sweep -> next cycle fword=0, pword=0, wave_shape=0, busy=0, cfg_ready=1, done=0.
2. cfg start=100, stop=130, step=10, dwell=2, mode=single; start at t -> fword=100 t+1..t+3, 110 t+4..t+6, 120 t+7..t+9, 130 t+10..t+12. step_strobe at t+4, t+7, t+10. done=1 and busy=0 at t+13; fword stays 130.
3. Saturation: start=1000, stop=1020, step=15, dwell=0, single -> fword 1000, 1015, 1020, then done. Overflow: start=1000, stop=1023, step=100 -> 1000, 1023, done.
4. Up-down: start=10, stop=30, step=10, dwell=0 -> fword 10, 20, 30, 20, 10, 20, 30… one cycle each, step_strobe every cycle after the first; no done.
5. Repeat: start=100, stop=120, step=10, dwell=1 -> fword 100, 110, 120, 100… each for 2 cycles, step_strobe on the 120→100 wrap. Assert stop mid-value -> busy=0 next cycle, fword frozen, done stays 0.
6. Rejections: cfg_valid during busy -> cfg_ready=0 and shadow unchanged. Start with start=50, stop=40 -> busy stays 0. Start with stop both high in IDLE -> ignored. Step=0 -> sweeps in increments of 1.
